gpio_bus_arbiter: RTL and testbench

//  Shares the single register bus of one gpio_output_ip instance between NUM_REQ requesters
//  (e.g. CPU port, pattern sequencer).
//  - Round-robin grant; one transaction in flight at a time.
//  - Drives the GPIO chip_select/write_enable/read_enable strobes for exactly one cycle each.
//  - Returns a per-requester completion with read data or an address-window error.

---
 rtl/gpio_bus_arbiter_if.sv | 34 +++
 rtl/gpio_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_arbiter_if.sv
// Bundles the requester handshake and the GPIO register bus shared through gpio_bus_arbiter.
// "master" is the environment side (requesters + GPIO IP); "slave" is the arbiter side.
interface gpio_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic                  rsp_err;
    logic [DW-1:0]         rsp_rdata;
    logic                  gpio_cs;
    logic                  gpio_we;
    logic                  gpio_re;
    logic [AW-1:0]         gpio_addr;
    logic [DW-1:0]         gpio_wdata;
    logic [DW-1:0]         gpio_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, gpio_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               gpio_cs, gpio_we, gpio_re, gpio_addr, gpio_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, gpio_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               gpio_cs, gpio_we, gpio_re, gpio_addr, gpio_wdata
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one gpio_output_ip register bus between NUM_REQ requesters,
// one transaction in flight, with address-window checking and per-requester completions.
module gpio_bus_arbiter #(
    parameter int            NUM_REQ    = 2,
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter logic [AW-1:0] BASE_ADDR  = 'h2000_0000,
    parameter logic [AW-1:0] WIN_MASK   = 'hFFFF_FFF0,
    parameter int            RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    gpio_bus_arbiter_if.slave   bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   pick;
    logic            any_valid;
    logic            legal;
    int unsigned     idx;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            write_q;
    logic            err_q;
    logic [2:0]      cnt;

    // Scanning offsets from highest to lowest lets the nearest valid requester win.
    always_comb begin
        pick      = rr_ptr;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                pick      = IW'(idx);
                any_valid = 1'b1;
            end
        end
        legal = ((bus.req_addr[pick*AW +: AW] & WIN_MASK) == BASE_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = legal ? ISSUE : RESP;
            ISSUE:   next_state = write_q ? RESP : WAIT;
            WAIT:    if (cnt == 3'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            grant   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant   <= pick;
                        addr_q  <= bus.req_addr[pick*AW +: AW];
                        wdata_q <= bus.req_wdata[pick*DW +: DW];
                        write_q <= bus.req_write[pick];
                        err_q   <= ~legal;
                        rdata_q <= '0;
                    end
                end
                ISSUE: cnt <= 3'(RD_LATENCY - 1);
                WAIT: begin
                    if (cnt == 3'd0) begin
                        rdata_q <= bus.gpio_rdata;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                default: ;
            endcase
        end
    end

    // req_ready is gated by rst_n so every output is quiet while reset is held.
    always_comb begin
        bus.req_ready  = '0;
        bus.rsp_valid  = '0;
        bus.rsp_err    = 1'b0;
        bus.rsp_rdata  = '0;
        bus.gpio_cs    = (state == ISSUE);
        bus.gpio_we    = (state == ISSUE) && write_q;
        bus.gpio_re    = (state == ISSUE) && !write_q;
        bus.gpio_addr  = addr_q;
        bus.gpio_wdata = wdata_q;
        if (rst_n && state == IDLE && any_valid) begin
            bus.req_ready[pick] = 1'b1;
        end
        if (state == RESP) begin
            bus.rsp_valid[grant] = 1'b1;
            bus.rsp_err          = err_q;
            bus.rsp_rdata        = rdata_q;
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench for gpio_bus_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level round-robin/memory model.
module tb_gpio_bus_arbiter;

    localparam int          N    = 2;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          L    = 2;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FFF0;

    typedef struct {
        int          req;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_bus_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

    gpio_bus_arbiter #(
        .NUM_REQ(N), .AW(AW), .DW(DW),
        .BASE_ADDR(BASE), .WIN_MASK(MASK), .RD_LATENCY(L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // GPIO IP stand-in: four registers, read data valid L cycles after gpio_re, junk otherwise.
    logic [31:0] gmem [4] = '{default: '0};
    logic        pv   [L] = '{default: 1'b0};
    logic [31:0] pd   [L];

    always @(posedge clk) begin
        if (bus.gpio_cs && bus.gpio_we) gmem[bus.gpio_addr[3:2]] <= bus.gpio_wdata;
        pv[0] <= bus.gpio_cs && bus.gpio_re;
        pd[0] <= gmem[bus.gpio_addr[3:2]];
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign bus.gpio_rdata = pv[L-1] ? pd[L-1] : (32'hBAD0_0000 | 32'(cyc));

    // Reference model state.
    exp_t        sbq [$];
    logic [31:0] ref_mem [4] = '{default: '0};
    int          ptr_m = 0;
    int          busy_until = -1;
    int          strobe_cyc = -1;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    int          g;
    logic [N-1:0] exp_ready;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_write;
    logic        m_legal;
    exp_t        m_exp;

    // Accept side: predicts grants and GPIO strobes, pushes expected completions.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            ptr_m      = 0;
            busy_until = -1;
            strobe_cyc = -1;
        end else begin
            if (cyc == strobe_cyc || bus.gpio_cs) begin
                checkOutput("gpio_strobe", {bus.gpio_cs, bus.gpio_we, bus.gpio_re},
                            (cyc == strobe_cyc) ? {1'b1, s_we, ~s_we} : 3'b000);
                if (cyc == strobe_cyc) begin
                    checkOutput("gpio_addr", bus.gpio_addr, s_addr);
                    if (s_we) checkOutput("gpio_wdata", bus.gpio_wdata, s_data);
                end
            end
            if (bus.req_valid != '0 || bus.req_ready != '0) begin
                g = -1;
                exp_ready = '0;
                if (cyc > busy_until) begin
                    for (int k = 0; k < N; k++)
                        if (g < 0 && bus.req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
                checkOutput("req_ready", bus.req_ready, exp_ready);
                if (g >= 0) begin
                    m_addr  = bus.req_addr[g*AW +: AW];
                    m_data  = bus.req_wdata[g*DW +: DW];
                    m_write = bus.req_write[g];
                    m_legal = ((m_addr & MASK) == BASE);
                    m_exp.req = g;
                    m_exp.err = !m_legal;
                    m_exp.rdata = '0;
                    if (!m_legal) begin
                        m_exp.due = cyc + 1;
                    end else if (m_write) begin
                        ref_mem[m_addr[3:2]] = m_data;
                        m_exp.due = cyc + 2;
                    end else begin
                        m_exp.rdata = ref_mem[m_addr[3:2]];
                        m_exp.due = cyc + 2 + L;
                    end
                    if (m_legal) begin
                        strobe_cyc = cyc + 1;
                        s_we   = m_write;
                        s_addr = m_addr;
                        s_data = m_data;
                    end
                    sbq.push_back(m_exp);
                    ptr_m      = (g + 1) % N;
                    busy_until = m_exp.due;
                end
            end
        end
    end

    exp_t mon_e;

    // Completion side: pops and compares whenever a response appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_rsp", bus.rsp_valid, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("rsp_valid", bus.rsp_valid, 64'(1) << mon_e.req);
                    checkOutput("rsp_err", bus.rsp_err, mon_e.err);
                    checkOutput("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                    checkOutput("rsp_cycle", cyc, mon_e.due);
                end
            end else begin
                checkOutput("rsp_idle_zero", {bus.rsp_err, bus.rsp_rdata}, 0);
                if (sbq.size() > 0 && cyc > sbq[0].due) begin
                    checkOutput("rsp_timeout", cyc, sbq[0].due);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    logic [N-1:0] rdy;

    task automatic raise(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[i]         = 1'b1;
        bus.req_write[i]         = w;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic waitAccept();
        for (int t = 0; t < 60 && bus.req_valid != '0; t++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            bus.req_valid = bus.req_valid & ~rdy;
        end
        if (bus.req_valid != '0) begin
            checkOutput("accept_timeout", bus.req_valid, 0);
            bus.req_valid = '0;
        end
    endtask

    task automatic applyStimulus(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        raise(i, w, a, d);
        waitAccept();
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 60 && sbq.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (sbq.size() != 0) checkOutput("drain_timeout", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.gpio_cs, bus.gpio_we, bus.gpio_re}, 0);
        checkOutput("reset_gpio_addr", bus.gpio_addr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single write");
        applyStimulus(0, 1'b1, BASE, 32'h1234_5678);
        waitDrain();
        checkOutput("t2_gpio_out", gmem[0], 32'h1234_5678);

        $display("[TB] read-back");
        applyStimulus(1, 1'b0, BASE, 32'h0);
        waitDrain();

        $display("[TB] contention");
        for (int r = 0; r < 2; r++) begin
            raise(0, 1'b1, BASE, 32'hDEAD_BEEF);
            raise(1, 1'b1, BASE, 32'hCAFE_F00D);
            waitAccept();
            waitDrain();
            checkOutput("t4_gpio_out", gmem[0], ref_mem[0]);
        end
        checkOutput("t4_final", gmem[0], 32'hCAFE_F00D);

        $display("[TB] bad address");
        applyStimulus(0, 1'b0, 32'h3000_0000, 32'h0);
        waitDrain();

        $display("[TB] withdraw");
        applyStimulus(0, 1'b0, BASE + 32'h4, 32'h0);
        raise(1, 1'b1, BASE + 32'h8, 32'h5555_AAAA);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        waitDrain();
        checkOutput("t6_no_write", gmem[2], 32'h0);

        $display("[TB] reset mid-read");
        applyStimulus(0, 1'b0, BASE, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t1_outputs",
                    {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.gpio_cs, bus.gpio_we, bus.gpio_re}, 0);
        checkOutput("t1_rdata", bus.rsp_rdata, 0);
        checkOutput("t1_gpio_addr", {bus.gpio_addr, bus.gpio_wdata}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(1, 1'b1, BASE + 32'hC, 32'hA5A5_5A5A);
        waitDrain();
        checkOutput("t1_after_reset", gmem[3], 32'hA5A5_5A5A);

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i]) begin
                    if (rdy[i] || $urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    raise(i, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 3) * 4)),
                          $urandom);
                end
            end
        end
        bus.req_valid = '0;
        waitDrain();
        for (int w = 0; w < 4; w++) checkOutput("final_mem", gmem[w], ref_mem[w]);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
